// File: rtl/bp_serial_flit_framer.sv
// bp_serial_flit_framer
// Transmit-side serialiser in front of the serial link. One wide message is taken
// per valid/ready handshake and sent LSB-first as a run of flits, the final one
// tagged with link_last_o. Flits only leave while the receiver has granted credit.

module bp_serial_flit_framer #(
  parameter int data_width_p   = 64,
  parameter int packet_width_p = 16,
  parameter int credits_p      = 4,
  localparam int num_packets_lp = (data_width_p + packet_width_p - 1) / packet_width_p,
  localparam int credit_w_lp    = $clog2(credits_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [data_width_p-1:0]   data_i,
  output logic                      ready_o,
  output logic                      link_v_o,
  output logic [packet_width_p-1:0] link_data_o,
  output logic                      link_last_o,
  input  logic                      credit_i,
  output logic [credit_w_lp-1:0]    credits_o,
  output logic                      overflow_o
);

  localparam int idx_w_lp    = $clog2(num_packets_lp);
  localparam int padded_w_lp = num_packets_lp * packet_width_p;

  localparam logic [idx_w_lp-1:0]    last_idx_lp   = idx_w_lp'(num_packets_lp - 1);
  localparam logic [credit_w_lp-1:0] credit_max_lp = credit_w_lp'(credits_p);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Message holding stage: the accepted payload and the slice pointer into it.
  state_e                    state_p0;
  logic [padded_w_lp-1:0]    payload_p0;
  logic [idx_w_lp-1:0]       idx_p0;
  logic                      ready_r;

  // Link stage: the flit registered onto the link.
  logic                      vld_p1;
  logic [packet_width_p-1:0] data_p1;
  logic                      last_p1;

  logic [credit_w_lp-1:0]    credits_r;
  logic                      overflow_r;

  logic [packet_width_p-1:0] slices [num_packets_lp];
  logic                      fire;
  logic                      is_last;
  logic [credit_w_lp:0]      credit_next;

  // Credit bookkeeping: returns {overflow_event, next_count}. A spend and a return
  // in the same cycle cancel; a return with the counter already full saturates and
  // flags overflow instead of wrapping.
  function automatic logic [credit_w_lp:0] credit_update(
    input logic [credit_w_lp-1:0] cur,
    input logic                   spend,
    input logic                   give
  );
    logic [credit_w_lp:0] r;
    r = {1'b0, cur};
    if (spend && !give) begin
      r = {1'b0, cur - credit_w_lp'(1)};
    end else if (give && !spend) begin
      if (cur == credit_max_lp) r = {1'b1, cur};
      else                      r = {1'b0, cur + credit_w_lp'(1)};
    end
    return r;
  endfunction

  // The payload is zero-padded to a whole number of flits, so the top slice
  // naturally carries the leftover bits with zero fill above them.
  for (genvar k = 0; k < num_packets_lp; k++) begin : g_slice
    assign slices[k] = payload_p0[k*packet_width_p +: packet_width_p];
  end

  // Fire decision uses only registered state, so no input reaches an output combinationally.
  assign fire        = (state_p0 == SEND) && (credits_r != '0);
  assign is_last     = (idx_p0 == last_idx_lp);
  assign credit_next = credit_update(credits_r, fire, credit_i);

  // Message FSM: accept in IDLE, walk the slices in SEND, return to IDLE after the last flit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_p0   <= IDLE;
      payload_p0 <= '0;
      idx_p0     <= '0;
      ready_r    <= 1'b1;
    end else begin
      case (state_p0)
        IDLE: begin
          if (v_i && ready_r) begin
            payload_p0 <= padded_w_lp'(data_i);
            idx_p0     <= '0;
            state_p0   <= SEND;
            ready_r    <= 1'b0;
          end
        end
        SEND: begin
          if (fire) begin
            idx_p0 <= idx_p0 + idx_w_lp'(1);
            if (is_last) begin
              state_p0 <= IDLE;
              ready_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_p0 <= IDLE;
          ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Link output register: data and last are forced to zero in cycles without a flit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= fire;
      data_p1 <= fire ? slices[idx_p0] : '0;
      last_p1 <= fire && is_last;
    end
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r  <= credit_max_lp;
      overflow_r <= 1'b0;
    end else begin
      credits_r <= credit_next[credit_w_lp-1:0];
      if (credit_next[credit_w_lp]) overflow_r <= 1'b1;
    end
  end

  assign ready_o     = ready_r;
  assign link_v_o    = vld_p1;
  assign link_data_o = data_p1;
  assign link_last_o = last_p1;
  assign credits_o   = credits_r;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_bp_serial_flit_framer.sv
// Bench for bp_serial_flit_framer: a flit-queue reference model checked every cycle,
// plus literal expectations for the directed scenarios.

module tb_bp_serial_flit_framer;

  localparam int DW = 40;
  localparam int PW = 16;
  localparam int CR = 2;
  localparam int NP = (DW + PW - 1) / PW;
  localparam int CW = $clog2(CR + 1);

  logic          clk;
  logic          reset_i;
  logic          v_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          link_v_o;
  logic [PW-1:0] link_data_o;
  logic          link_last_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
  logic          overflow_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit auto_cr = 0;

  bp_serial_flit_framer #(
    .data_width_p  (DW),
    .packet_width_p(PW),
    .credits_p     (CR)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .link_v_o   (link_v_o),
    .link_data_o(link_data_o),
    .link_last_o(link_last_o),
    .credit_i   (credit_i),
    .credits_o  (credits_o),
    .overflow_o (overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending flits, a credit integer and a sticky flag.
  logic [PW-1:0] m_qd [$];
  bit            m_ql [$];
  int            m_cred;
  bit            m_ovf;
  bit            m_v;
  logic [PW-1:0] m_d;
  bit            m_l;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_qd.delete();
      m_ql.delete();
      m_cred <= CR;
      m_ovf  <= 1'b0;
      m_v    <= 1'b0;
      m_d    <= '0;
      m_l    <= 1'b0;
    end else begin : upd
      automatic bit fire = (m_qd.size() != 0) && (m_cred > 0);
      automatic bit acc  = v_i && (m_qd.size() == 0);
      automatic int nc   = m_cred - (fire ? 1 : 0) + (credit_i ? 1 : 0);
      if (nc > CR) begin
        nc = CR;
        m_ovf <= 1'b1;
      end
      m_cred <= nc;
      if (fire) begin
        m_v <= 1'b1;
        m_d <= m_qd.pop_front();
        m_l <= m_ql.pop_front();
      end else begin
        m_v <= 1'b0;
        m_d <= '0;
        m_l <= 1'b0;
      end
      if (acc) begin
        for (int k = 0; k < NP; k++) begin
          m_qd.push_back(PW'(data_i >> (PW * k)));
          m_ql.push_back(k == NP - 1);
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("ready",     64'(ready_o),     64'(m_qd.size() == 0));
    check("link_v",    64'(link_v_o),    64'(m_v));
    check("link_data", 64'(link_data_o), 64'(m_d));
    check("link_last", 64'(link_last_o), 64'(m_l));
    check("credits",   64'(credits_o),   64'(m_cred));
    check("overflow",  64'(overflow_o),  64'(m_ovf));
  end

  // Flit log for the literal checks.
  logic [PW-1:0] cap_d [$];
  bit            cap_l [$];
  int            cap_c [$];
  int            cap_cr[$];

  always @(negedge clk) begin
    if (!reset_i && link_v_o) begin
      cap_d.push_back(link_data_o);
      cap_l.push_back(link_last_o);
      cap_c.push_back(cyc);
      cap_cr.push_back(int'(credits_o));
    end
  end

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    cap_c.delete();
    cap_cr.delete();
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit cr);
    @(negedge clk);
    v_i      = v;
    data_i   = d;
    credit_i = cr | (auto_cr & link_v_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p;
    bit reached;
    reset_i  = 1'b1;
    v_i      = 1'b0;
    data_i   = '0;
    credit_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",    64'(ready_o),    64'd1);
    check("rst_link_v",   64'(link_v_o),   64'd0);
    check("rst_credits",  64'(credits_o),  64'd2);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    reset_i = 1'b0;
    repeat (2) step(0, '0, 0);

    // Single message with a credit returned one cycle after each flit.
    auto_cr = 1;
    clear_cap();
    step(1, 40'hAB_CDEF_1234, 0);
    repeat (8) step(0, '0, 0);
    check("t2_count", 64'(cap_d.size()), 64'd3);
    if (cap_d.size() >= 3) begin
      check("t2_f0", 64'(cap_d[0]), 64'h1234);
      check("t2_f1", 64'(cap_d[1]), 64'hCDEF);
      check("t2_f2", 64'(cap_d[2]), 64'h00AB);
      check("t2_l0", 64'(cap_l[0]), 64'd0);
      check("t2_l1", 64'(cap_l[1]), 64'd0);
      check("t2_l2", 64'(cap_l[2]), 64'd1);
      check("t4_b2b_1", 64'(cap_c[1] - cap_c[0]), 64'd1);
      check("t4_b2b_2", 64'(cap_c[2] - cap_c[1]), 64'd1);
      check("t4_cred_1", 64'(cap_cr[1]), 64'd1);
      check("t4_cred_2", 64'(cap_cr[2]), 64'd1);
    end
    check("t2_ready_after",   64'(ready_o),   64'd1);
    check("t2_credits_after", 64'(credits_o), 64'd2);

    // Credit starvation: two flits, stall, single credit releases the last flit.
    auto_cr = 0;
    clear_cap();
    step(1, 40'h12_3456_789A, 0);
    p = cyc + 1;
    repeat (5) step(0, '0, 0);
    check("t3_stall_credits", 64'(credits_o), 64'd0);
    check("t3_stall_v",       64'(link_v_o),  64'd0);
    check("t3_stall_ready",   64'(ready_o),   64'd0);
    repeat (4) step(0, '0, 0);
    step(0, '0, 1);
    repeat (3) step(0, '0, 0);
    check("t3_count", 64'(cap_d.size()), 64'd3);
    if (cap_d.size() >= 3) begin
      check("t3_f0", 64'(cap_d[0]), 64'h789A);
      check("t3_f1", 64'(cap_d[1]), 64'h3456);
      check("t3_f2", 64'(cap_d[2]), 64'h0012);
      check("t3_c0", 64'(cap_c[0] - p), 64'd1);
      check("t3_c1", 64'(cap_c[1] - p), 64'd2);
      check("t3_c2", 64'(cap_c[2] - p), 64'd11);
      check("t3_l2", 64'(cap_l[2]), 64'd1);
    end

    // Refill, then one surplus credit while idle.
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);
    check("t5_full",     64'(credits_o),  64'd2);
    check("t5_no_ovf",   64'(overflow_o), 64'd0);
    step(0, '0, 1);
    step(0, '0, 0);
    check("t5_credits",  64'(credits_o),  64'd2);
    check("t5_ovf",      64'(overflow_o), 64'd1);
    repeat (3) step(0, '0, 0);
    check("t5_ovf_sticky", 64'(overflow_o), 64'd1);

    // Reset mid-message after flit 1, asserted between clock edges.
    auto_cr = 1;
    clear_cap();
    step(1, 40'hFE_DCBA_9876, 0);
    reached = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 0);
      #1;
      if (cap_d.size() >= 2) begin
        reached = 1;
        break;
      end
    end
    check("t6_reach", 64'(reached), 64'd1);
    check("t6_pre_v", 64'(link_v_o), 64'd1);
    if (cap_d.size() >= 2) begin
      check("t6_f0", 64'(cap_d[0]), 64'h9876);
      check("t6_f1", 64'(cap_d[1]), 64'hDCBA);
    end
    #1;
    auto_cr  = 0;
    credit_i = 1'b0;
    reset_i  = 1'b1;
    #1;
    check("t1_async_ready",   64'(ready_o),     64'd1);
    check("t1_async_v",       64'(link_v_o),    64'd0);
    check("t1_async_data",    64'(link_data_o), 64'd0);
    check("t1_async_credits", 64'(credits_o),   64'd2);
    check("t1_async_ovf",     64'(overflow_o),  64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (5) step(0, '0, 0);
    check("t6_no_flit2", 64'(cap_d.size()), 64'd2);
    check("t6_credits",  64'(credits_o),    64'd2);

    auto_cr = 1;
    clear_cap();
    step(1, 40'h01_0203_0405, 0);
    repeat (7) step(0, '0, 0);
    check("t6_next_count", 64'(cap_d.size()), 64'd3);
    if (cap_d.size() >= 3) begin
      check("t6_next_f0", 64'(cap_d[0]), 64'h0405);
      check("t6_next_l0", 64'(cap_l[0]), 64'd0);
      check("t6_next_f2", 64'(cap_d[2]), 64'h0001);
      check("t6_next_l2", 64'(cap_l[2]), 64'd1);
    end

    auto_cr = 0;
    repeat (2) step(0, '0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
